// File: rtl/eda_regional_max_iter.sv
// Regional-maxima mask of an M x N image by iterative flag propagation.
// A flag survives only if no neighbour is higher and no equal neighbour has lost its flag.
module eda_regional_max_iter #(
    parameter int M           = 8,
    parameter int N           = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int I_WIDTH     = 3,
    parameter int J_WIDTH     = 3,
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH,
    parameter int MAX_ITER    = M * N,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [PIXEL_WIDTH-1:0]      pixel_in,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic                        write_en,
    input  logic                        start,
    input  logic                        conn8,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic [CNT_WIDTH-1:0]        iter_count,
    output logic [M-1:0][N-1:0]         matrix_output
);

    typedef enum logic [1:0] {IDLE, INIT, ITER} state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_ITER);

    state_t                 state;
    logic [PIXEL_WIDTH-1:0] img [M][N];
    logic [M-1:0][N-1:0]    flag;
    logic [M-1:0][N-1:0]    flag_next;
    logic                   conn8_q;
    logic [I_WIDTH-1:0]     wr_row;
    logic [J_WIDTH-1:0]     wr_col;
    logic [CNT_WIDTH-1:0]   iter_next;

    assign wr_row    = wr_addr[I_WIDTH+J_WIDTH-1:J_WIDTH];
    assign wr_col    = wr_addr[J_WIDTH-1:0];
    assign iter_next = iter_count + 1'b1;

    // Neighbour d: 0..2 row above, 3..4 same row, 5..7 row below; border neighbours are not generated.
    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [7:0] kill;
            for (genvar d = 0; d < 8; d++) begin : g_nb
                localparam int DI = (d < 3) ? -1 : (d < 5) ? 0 : 1;
                localparam int DJ = (d == 0 || d == 3 || d == 5) ? -1 :
                                    (d == 1 || d == 6) ? 0 : 1;
                localparam bit ORTHO = (DI == 0) || (DJ == 0);
                if ((i + DI >= 0) && (i + DI < M) && (j + DJ >= 0) && (j + DJ < N)) begin : g_in
                    assign kill[d] = (ORTHO || conn8_q) &&
                                     ((img[i+DI][j+DJ] > img[i][j]) ||
                                      ((img[i+DI][j+DJ] == img[i][j]) && !flag[i+DI][j+DJ]));
                end else begin : g_out
                    assign kill[d] = 1'b0;
                end
            end
            assign flag_next[i][j] = flag[i][j] & ~(|kill);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            iter_count    <= '0;
            matrix_output <= '0;
            flag          <= '0;
            conn8_q       <= 1'b0;
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    img[r][c] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Address decode against every cell also rejects out-of-image rows/columns.
                    for (int r = 0; r < M; r++) begin
                        for (int c = 0; c < N; c++) begin
                            if (write_en && wr_row == I_WIDTH'(r) && wr_col == J_WIDTH'(c)) begin
                                img[r][c] <= pixel_in;
                            end
                        end
                    end
                    if (start) begin
                        conn8_q <= conn8;
                        busy    <= 1'b1;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    flag       <= '1;
                    iter_count <= '0;
                    state      <= ITER;
                end
                ITER: begin
                    flag       <= flag_next;
                    iter_count <= iter_next;
                    if (flag_next == flag) begin
                        matrix_output <= flag_next;
                        done          <= 1'b1;
                        timeout       <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else if (iter_next == MAX_CNT) begin
                        matrix_output <= flag_next;
                        done          <= 1'b1;
                        timeout       <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eda_regional_max_iter.sv
// Bench for eda_regional_max_iter: an 8x8 instance and an 8x7 instance with MAX_ITER=4,
// checked against a plateau-distance model of regional maxima.
module tb_eda_regional_max_iter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  pixA = '0, pixB = '0;
    logic [5:0]  addrA = '0;
    logic [6:0]  addrB = '0;
    logic        weA = 1'b0, weB = 1'b0, startA = 1'b0, startB = 1'b0, c8A = 1'b0, c8B = 1'b0;
    logic        busyA, busyB, doneA, doneB, toA, toB;
    logic [15:0] iterA, iterB;
    logic [63:0] maskA;
    logic [55:0] maskB;

    eda_regional_max_iter dutA (
        .clk(clk), .reset_n(reset_n), .pixel_in(pixA), .wr_addr(addrA), .write_en(weA),
        .start(startA), .conn8(c8A), .busy(busyA), .done(doneA), .timeout(toA),
        .iter_count(iterA), .matrix_output(maskA)
    );

    eda_regional_max_iter #(.N(7), .J_WIDTH(4), .MAX_ITER(4)) dutB (
        .clk(clk), .reset_n(reset_n), .pixel_in(pixB), .wr_addr(addrB), .write_en(weB),
        .start(startB), .conn8(c8B), .busy(busyB), .done(doneB), .timeout(toB),
        .iter_count(iterB), .matrix_output(maskB)
    );

    int cmpCount = 0;
    int errCount = 0;
    int imA [8][8];
    int imB [8][8];
    logic [63:0] expMask [2];
    int expIter [2];
    bit expTo [2];
    longint t0 [2];
    int doneCnt [2];
    int baseCnt [2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit isNb(input int dr, input int dc, input bit c8);
        return (dr != 0 || dc != 0) && (c8 || dr == 0 || dc == 0);
    endfunction

    // Each non-maximal plateau pixel loses its flag at 1 + (distance within the plateau
    // to a pixel that touches something higher); the run ends one iteration after the last loss.
    function automatic void model(input int im [8][8], input int rows, input int cols, input bit c8,
                                  input int maxIter, output logic [63:0] mask, output int iters,
                                  output bit to);
        int ct [8][8];
        bit chg;
        int maxc, limit, rr, cc;
        maxc = 0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                ct[r][c] = 100000;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr; cc = c + dc;
                        if (isNb(dr, dc, c8) && rr >= 0 && rr < rows && cc >= 0 && cc < cols)
                            if (im[rr][cc] > im[r][c]) ct[r][c] = 1;
                    end
            end
        chg = 1'b1;
        while (chg) begin
            chg = 1'b0;
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++)
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
                            rr = r + dr; cc = c + dc;
                            if (isNb(dr, dc, c8) && rr >= 0 && rr < rows && cc >= 0 && cc < cols)
                                if (im[rr][cc] == im[r][c] && ct[rr][cc] + 1 < ct[r][c]) begin
                                    ct[r][c] = ct[rr][cc] + 1;
                                    chg = 1'b1;
                                end
                        end
        end
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                if (ct[r][c] < 100000 && ct[r][c] > maxc) maxc = ct[r][c];
        if (maxc + 1 > maxIter) begin
            to = 1'b1; iters = maxIter; limit = maxIter;
        end else begin
            to = 1'b0; iters = maxc + 1; limit = maxc + 1;
        end
        mask = '0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                if (ct[r][c] > limit) mask[r*cols+c] = 1'b1;
    endfunction

    // Compare process: every completion pulse is checked against the model's prediction.
    always @(negedge clk) begin
        if (reset_n && doneA) begin
            checkOutput("A mask", maskA, expMask[0]);
            checkOutput("A iter_count", 64'(iterA), 64'(expIter[0]));
            checkOutput("A timeout", 64'(toA), 64'(expTo[0]));
            checkOutput("A latency", 64'(($time - t0[0] - 5) / 10), 64'(expIter[0] + 1));
            doneCnt[0]++;
        end
        if (reset_n && doneB) begin
            checkOutput("B mask", {8'b0, maskB}, expMask[1]);
            checkOutput("B iter_count", 64'(iterB), 64'(expIter[1]));
            checkOutput("B timeout", 64'(toB), 64'(expTo[1]));
            checkOutput("B latency", 64'(($time - t0[1] - 5) / 10), 64'(expIter[1] + 1));
            doneCnt[1]++;
        end
    end

    task automatic modelWrite(input int sel, input int r, input int c, input int v);
        if (sel == 0 && r < 8 && c < 8) imA[r][c] = v;
        if (sel == 1 && r < 8 && c < 7) imB[r][c] = v;
    endtask

    task automatic writePix(input int sel, input int r, input int c, input int v, input bit track);
        if (sel == 0) begin
            addrA = {r[2:0], c[2:0]}; pixA = v[7:0]; weA = 1'b1;
        end else begin
            addrB = {r[2:0], c[3:0]}; pixB = v[7:0]; weB = 1'b1;
        end
        @(posedge clk);
        #1 weA = 1'b0; weB = 1'b0;
        if (track) modelWrite(sel, r, c, v);
    endtask

    task automatic fill(input int sel, input int v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < ((sel == 0) ? 8 : 7); c++)
                writePix(sel, r, c, v, 1'b1);
    endtask

    task automatic launch(input int sel, input bit c8, input bit wr, input int r, input int c,
                          input int v);
        logic [63:0] m;
        int it;
        bit to;
        if (wr) modelWrite(sel, r, c, v);
        if (sel == 0) model(imA, 8, 8, c8, 64, m, it, to);
        else          model(imB, 8, 7, c8, 4, m, it, to);
        expMask[sel] = m; expIter[sel] = it; expTo[sel] = to;
        if (sel == 0) begin
            c8A = c8; startA = 1'b1;
            if (wr) begin addrA = {r[2:0], c[2:0]}; pixA = v[7:0]; weA = 1'b1; end
        end else begin
            c8B = c8; startB = 1'b1;
            if (wr) begin addrB = {r[2:0], c[3:0]}; pixB = v[7:0]; weB = 1'b1; end
        end
        baseCnt[sel] = doneCnt[sel];
        @(posedge clk);
        t0[sel] = $time;
        #1 startA = 1'b0; startB = 1'b0; weA = 1'b0; weB = 1'b0;
    endtask

    task automatic waitDone(input int sel);
        int n = 0;
        while (doneCnt[sel] == baseCnt[sel] && n < 400) begin
            @(negedge clk);
            #1 n++;
        end
        checkOutput("done seen", 64'(doneCnt[sel] - baseCnt[sel]), 64'd1);
    endtask

    task automatic applyStimulus(input int sel, input bit c8, input bit wr, input int r,
                                 input int c, input int v);
        launch(sel, c8, wr, r, c, v);
        waitDone(sel);
    endtask

    task automatic plateauA();
        fill(0, 0);
        for (int c = 0; c < 8; c++) writePix(0, 0, c, 7, 1'b1);
        writePix(0, 1, 7, 8, 1'b1);
    endtask

    initial begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin imA[r][c] = 0; imB[r][c] = 0; end
        doneCnt[0] = 0; doneCnt[1] = 0;
        #23 reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset busy", 64'(busyA), 64'd0);
        checkOutput("reset done", 64'(doneA), 64'd0);
        checkOutput("reset timeout", 64'(toA), 64'd0);
        checkOutput("reset iter_count", 64'(iterA), 64'd0);
        checkOutput("reset mask", maskA, 64'd0);

        $display("[TB] uniform image");
        fill(0, 8'h33);
        applyStimulus(0, 1'b1, 1'b0, 0, 0, 0);
        checkOutput("uniform mask", maskA, {64{1'b1}});
        checkOutput("uniform iter", 64'(iterA), 64'd1);

        $display("[TB] connectivity");
        fill(0, 0);
        writePix(0, 0, 0, 5, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 1, 1, 9);
        checkOutput("conn8 mask", maskA, 64'h200);
        applyStimulus(0, 1'b0, 1'b0, 0, 0, 0);
        checkOutput("conn4 mask", maskA, 64'h201);

        $display("[TB] plateau propagation");
        plateauA();
        applyStimulus(0, 1'b0, 1'b0, 0, 0, 0);
        checkOutput("plateau mask", maskA, 64'h8000);
        checkOutput("plateau iter", 64'(iterA), 64'd9);
        checkOutput("plateau timeout", 64'(toA), 64'd0);

        $display("[TB] guards while busy");
        launch(0, 1'b0, 1'b0, 0, 0, 0);
        @(posedge clk); #1;
        c8A = 1'b1;
        writePix(0, 3, 3, 255, 1'b0);
        startA = 1'b1;
        @(posedge clk); #1 startA = 1'b0;
        checkOutput("busy mid-run", 64'(busyA), 64'd1);
        checkOutput("mask held mid-run", maskA, 64'h8000);
        waitDone(0);
        repeat (15) @(negedge clk);
        #1 checkOutput("single done", 64'(doneCnt[0] - baseCnt[0]), 64'd1);
        applyStimulus(0, 1'b0, 1'b0, 0, 0, 0);
        checkOutput("image unchanged", maskA, 64'h8000);

        $display("[TB] timeout build");
        fill(1, 0);
        for (int c = 0; c < 7; c++) writePix(1, 0, c, 7, 1'b1);
        writePix(1, 1, 6, 8, 1'b1);
        writePix(1, 3, 8, 255, 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 0, 0, 0);
        checkOutput("B timeout set", 64'(toB), 64'd1);
        checkOutput("B iter cap", 64'(iterB), 64'd4);
        fill(1, 8'h33);
        applyStimulus(1, 1'b1, 1'b0, 0, 0, 0);
        checkOutput("B timeout clear", 64'(toB), 64'd0);
        checkOutput("B uniform mask", {8'b0, maskB}, {8'b0, {56{1'b1}}});

        $display("[TB] reset mid-run");
        plateauA();
        launch(0, 1'b0, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid reset busy", 64'(busyA), 64'd0);
        checkOutput("mid reset done", 64'(doneA), 64'd0);
        checkOutput("mid reset mask", maskA, 64'd0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin imA[r][c] = 0; imB[r][c] = 0; end
        #14 reset_n = 1'b1;
        @(posedge clk); #1;
        writePix(0, 0, 0, 5, 1'b1);
        writePix(0, 1, 1, 9, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 0, 0, 0);
        checkOutput("after reset mask", maskA, 64'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
